// File: rtl/fxp_alu_arbiter.sv
// fxp_alu_arbiter: round-robin scheduler that shares one set of
// combinational fixed-point add/sub, mul and div units among NREQ requesters.

module fxp_resize #(
   parameter int II    = 9,
   parameter int FI    = 8,
   parameter int OI    = 8,
   parameter int FO    = 8,
   parameter bit ROUND = 1,
   parameter bit ROOF  = 1
) (
   input  logic signed [II+FI-1:0] x,
   output logic [OI+FO-1:0]        y,
   output logic                    upflow,
   output logic                    downflow
);
   localparam int W = II + FI + OI + FO + 2;
   localparam logic signed [W-1:0] MX = (W'(1) <<< (OI+FO-1)) - W'(1);
   localparam logic signed [W-1:0] MN = ~MX;

   logic signed [W-1:0] xe, sc, tr, rb, rd;

   // floor to FO fraction bits, then optionally add back the half-LSB
   always_comb begin
      xe       = {{(W-II-FI){x[II+FI-1]}}, x};
      sc       = xe <<< FO;
      tr       = sc >>> FI;
      rb       = ROUND ? ((sc >>> (FI-1)) & W'(1)) : '0;
      rd       = tr + rb;
      y        = rd[OI+FO-1:0];
      upflow   = 1'b0;
      if (rd > MX) begin
         upflow = 1'b1;
         if (ROOF) y = MX[OI+FO-1:0];
      end else if (rd < MN) begin
         upflow = 1'b1;
         if (ROOF) y = MN[OI+FO-1:0];
      end
      downflow = (x != '0) && (rd == '0);
   end
endmodule

module comb_FixedPointAddSub #(
   parameter int WII   = 8,
   parameter int WIF   = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter bit ROOF  = 1,
   parameter bit ROUND = 1
) (
   input  logic [WII+WIF-1:0] ina,
   input  logic [WII+WIF-1:0] inb,
   input  logic               sub,
   output logic [WOI+WOF-1:0] out,
   output logic               upflow,
   output logic               downflow
);
   localparam int WI = WII + WIF;

   logic signed [WI:0] ae, be, sum;

   assign ae  = {ina[WI-1], ina};
   assign be  = {inb[WI-1], inb};
   assign sum = sub ? (ae - be) : (ae + be);

   fxp_resize #(
      .II(WII+1), .FI(WIF), .OI(WOI), .FO(WOF),
      .ROUND(ROUND), .ROOF(ROOF)
   ) u_rs (
      .x(sum), .y(out), .upflow(upflow), .downflow(downflow)
   );
endmodule

module comb_FixedPointMul #(
   parameter int WII   = 8,
   parameter int WIF   = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter bit ROOF  = 1,
   parameter bit ROUND = 1
) (
   input  logic [WII+WIF-1:0] ina,
   input  logic [WII+WIF-1:0] inb,
   output logic [WOI+WOF-1:0] out,
   output logic               upflow,
   output logic               downflow
);
   localparam int WI = WII + WIF;

   logic signed [2*WI-1:0] ae, be, prod;

   assign ae   = {{WI{ina[WI-1]}}, ina};
   assign be   = {{WI{inb[WI-1]}}, inb};
   assign prod = ae * be;

   fxp_resize #(
      .II(2*WII), .FI(2*WIF), .OI(WOI), .FO(WOF),
      .ROUND(ROUND), .ROOF(ROOF)
   ) u_rs (
      .x(prod), .y(out), .upflow(upflow), .downflow(downflow)
   );
endmodule

module comb_FixedPointDiv #(
   parameter int WII   = 8,
   parameter int WIF   = 8,
   parameter int WOI   = 8,
   parameter int WOF   = 8,
   parameter bit ROOF  = 1,
   parameter bit ROUND = 1
) (
   input  logic [WII+WIF-1:0] ina,
   input  logic [WII+WIF-1:0] inb,
   output logic [WOI+WOF-1:0] out,
   output logic               upflow,
   output logic               downflow
);
   localparam int WI = WII + WIF;
   localparam int WO = WOI + WOF;
   localparam int QW = WI + WOF + 2;

   logic signed [QW-1:0] num, den, quo;
   logic [WO-1:0]        rs_out;
   logic                 rs_up, rs_dn;

   // quotient keeps one guard fraction bit for rounding
   assign num = {{(WOF+2){ina[WI-1]}}, ina} << (WOF+1);
   assign den = (inb == '0) ? QW'(1) : {{(WOF+2){inb[WI-1]}}, inb};
   assign quo = num / den;

   fxp_resize #(
      .II(WI+1), .FI(WOF+1), .OI(WOI), .FO(WOF),
      .ROUND(ROUND), .ROOF(ROOF)
   ) u_rs (
      .x(quo), .y(rs_out), .upflow(rs_up), .downflow(rs_dn)
   );

   always_comb begin
      out      = rs_out;
      upflow   = rs_up;
      downflow = rs_dn;
      if (inb == '0) begin
         out      = ina[WI-1] ? {1'b1, {(WO-1){1'b0}}}
                              : {1'b0, {(WO-1){1'b1}}};
         upflow   = 1'b1;
         downflow = 1'b0;
      end
   end
endmodule

module fxp_alu_arbiter #(
   parameter int NREQ       = 4,
   parameter int WII        = 8,
   parameter int WIF        = 8,
   parameter int WOI        = 8,
   parameter int WOF        = 8,
   parameter bit ROOF       = 1,
   parameter bit ROUND      = 1,
   parameter int DIV_CYCLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [2*NREQ-1:0]           req_op,
   input  logic [NREQ*(WII+WIF)-1:0]   req_a,
   input  logic [NREQ*(WII+WIF)-1:0]   req_b,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NREQ)-1:0]     rsp_id,
   output logic [WOI+WOF-1:0]          rsp_data,
   output logic                        rsp_upflow,
   output logic                        rsp_downflow
);
   localparam int WI = WII + WIF;
   localparam int WO = WOI + WOF;
   localparam int IW = $clog2(NREQ);
   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] OP_DIV = 2'b11;
   localparam logic [IW:0] NR    = (IW+1)'(NREQ);

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] gnt;
   logic          gnt_any;
   logic [CW-1:0] cnt;
   logic [1:0]    op_r;
   logic [WI-1:0] a_r, b_r;
   logic [1:0]    op_sel;
   logic [WI-1:0] a_sel, b_sel;

   logic [WO-1:0] as_out, mu_out, dv_out, sel_out;
   logic          as_up, mu_up, dv_up, sel_up;
   logic          as_dn, mu_dn, dv_dn, sel_dn;

   // first valid index at or after ptr, wrapping mod NREQ
   always_comb begin : rr_search
      logic [IW:0] s;
      s       = '0;
      gnt_any = 1'b0;
      gnt     = '0;
      for (int k = 0; k < NREQ; k++) begin
         s = {1'b0, ptr} + (IW+1)'(k);
         if (s >= NR) s = s - NR;
         if (!gnt_any && req_valid[s[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt     = s[IW-1:0];
         end
      end
   end

   assign op_sel = req_op[{gnt, 1'b0} +: 2];
   assign a_sel  = req_a[gnt*WI +: WI];
   assign b_sel  = req_b[gnt*WI +: WI];

   always_comb begin
      req_ready = '0;
      if (!rst && state == S_IDLE && gnt_any)
         req_ready[gnt] = 1'b1;
   end

   // units see only the held operand registers; div is a multicycle path
   comb_FixedPointAddSub #(
      .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF),
      .ROOF(ROOF), .ROUND(ROUND)
   ) u_addsub (
      .ina(a_r), .inb(b_r), .sub(op_r[0]),
      .out(as_out), .upflow(as_up), .downflow(as_dn)
   );

   comb_FixedPointMul #(
      .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF),
      .ROOF(ROOF), .ROUND(ROUND)
   ) u_mul (
      .ina(a_r), .inb(b_r),
      .out(mu_out), .upflow(mu_up), .downflow(mu_dn)
   );

   comb_FixedPointDiv #(
      .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF),
      .ROOF(ROOF), .ROUND(ROUND)
   ) u_div (
      .ina(a_r), .inb(b_r),
      .out(dv_out), .upflow(dv_up), .downflow(dv_dn)
   );

   always_comb begin
      sel_out = as_out;
      sel_up  = as_up;
      sel_dn  = as_dn;
      unique case (op_r)
         2'b10: begin
            sel_out = mu_out;
            sel_up  = mu_up;
            sel_dn  = mu_dn;
         end
         2'b11: begin
            sel_out = dv_out;
            sel_up  = dv_up;
            sel_dn  = dv_dn;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ptr          <= '0;
         cnt          <= '0;
         op_r         <= '0;
         a_r          <= '0;
         b_r          <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_data     <= '0;
         rsp_upflow   <= 1'b0;
         rsp_downflow <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  op_r   <= op_sel;
                  a_r    <= a_sel;
                  b_r    <= b_sel;
                  rsp_id <= gnt;
                  cnt    <= (op_sel == OP_DIV) ? CW'(DIV_CYCLES-1) : '0;
                  ptr    <= (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_data     <= sel_out;
                  rsp_upflow   <= sel_up;
                  rsp_downflow <= sel_dn;
                  rsp_valid    <= 1'b1;
                  state        <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fxp_alu_arbiter.sv
// Scenario bench for fxp_alu_arbiter: queue of model results per grant,
// popped and compared when the response appears.
`timescale 1ns/1ps
module tb_fxp_alu_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int DIVC = 4;
   localparam int IW   = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [W-1:0]  data;
      logic          up;
      logic          dn;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [2*NREQ-1:0] req_op;
   logic [NREQ*W-1:0] req_a, req_b;
   logic              rsp_valid, rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [W-1:0]      rsp_data;
   logic              rsp_upflow, rsp_downflow;
   logic [W-1:0]      ref_a, ref_b, ref_out;
   logic              ref_up, ref_dn;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   fxp_alu_arbiter #(
      .NREQ(NREQ), .WII(8), .WIF(8), .WOI(8), .WOF(8),
      .ROOF(1'b1), .ROUND(1'b1), .DIV_CYCLES(DIVC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_upflow(rsp_upflow), .rsp_downflow(rsp_downflow)
   );

   comb_FixedPointAddSub #(
      .WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(1'b1), .ROUND(1'b1)
   ) u_ref (
      .ina(ref_a), .inb(ref_b), .sub(1'b1),
      .out(ref_out), .upflow(ref_up), .downflow(ref_dn)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 8.8 -> 8.8 reference: exact value, round half up, saturate
   function automatic exp_t model(input logic [1:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic [IW-1:0] id);
      longint sa, sb, v, r;
      int     sh;
      exp_t   e;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.id = id; e.up = 1'b0; e.dn = 1'b0; e.data = '0;
      sh = 0; v = 0;
      case (op)
         2'b00: v = sa + sb;
         2'b01: v = sa - sb;
         2'b10: begin v = sa * sb; sh = 8; end
         default: begin
            if (sb == 0) begin
               e.data = (sa < 0) ? 16'h8000 : 16'h7FFF;
               e.up = 1'b1;
               return e;
            end
            v = (sa * 512) / sb;
            sh = 1;
         end
      endcase
      r = longint'($floor(real'(v) / (2.0 ** sh) + 0.5));
      e.dn = (v != 0) && (r == 0);
      if (r > 32767) begin e.up = 1'b1; r = 32767; end
      else if (r < -32768) begin e.up = 1'b1; r = -32768; end
      e.data = r[15:0];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      req_op[2*i +: 2] = op;
      req_a[W*i +: W]  = a;
      req_b[W*i +: W]  = b;
   endtask

   task automatic issue(input int i, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output int tg);
      tg = -1;
      set_req(i, op, a, b);
      req_valid[i] = 1'b1;
      #1;
      for (int k = 0; k < 50; k++) begin
         if (req_ready[i]) begin tg = cyc; break; end
         tick();
      end
      if (tg >= 0) begin
         sbq.push_back(model(op, a, b, IW'(i)));
         tick();
      end
      req_valid[i] = 1'b0;
   endtask

   task automatic await_rsp(output int tr);
      tr = -1;
      for (int k = 0; k < 60; k++) begin
         if (rsp_valid) begin tr = cyc; break; end
         tick();
      end
   endtask

   function automatic exp_t pop_exp();
      exp_t e;
      e = '0;
      if (sbq.size() > 0) e = sbq.pop_front();
      return e;
   endfunction

   task automatic test_reset();
      int   tr;
      exp_t e;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 2'b00, 16'(256 * (i + 1)), 16'h0010);
      req_valid = '1;
      repeat (3) tick();
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_id !== '0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", rsp_id); end
      n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", rsp_data); end
      n_checks++; if ({rsp_upflow, rsp_downflow} !== 2'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00", {rsp_upflow, rsp_downflow}); end
      rst = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
      sbq.push_back(model(2'b00, 16'h0100, 16'h0010, 2'd0));
      tick();
      req_valid = '0;
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tr !== cyc || tr < 0) begin n_fail++; $display("FAIL rst_first_rsp: no response"); end
      n_checks++; if ({rsp_id, rsp_data} !== {e.id, e.data}) begin n_fail++; $display("FAIL rst_first_data: got %0d/%h want %0d/%h", rsp_id, rsp_data, e.id, e.data); end
      tick();
   endtask

   task automatic test_add();
      int   tg, tr;
      exp_t e;
      issue(0, 2'b00, 16'h0180, 16'h0240, tg);
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tg < 0 || tr != tg + 2) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", tr - tg, 2); end
      n_checks++; if (rsp_data !== 16'h03C0) begin n_fail++; $display("FAIL add_data: got %h want 03c0", rsp_data); end
      n_checks++; if ({rsp_id, rsp_upflow, rsp_downflow} !== {e.id, e.up, e.dn}) begin n_fail++; $display("FAIL add_id_flags: got %0d/%b%b want %0d/%b%b", rsp_id, rsp_upflow, rsp_downflow, e.id, e.up, e.dn); end
      tick();
   endtask

   task automatic test_mul_div();
      int   tg, tr;
      exp_t e;
      issue(2, 2'b10, 16'h0200, 16'h0180, tg);
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tg < 0 || tr != tg + 2) begin n_fail++; $display("FAIL mul_latency: got %0d want 2", tr - tg); end
      n_checks++; if ({rsp_id, rsp_data} !== {2'd2, 16'h0300}) begin n_fail++; $display("FAIL mul_data: got %0d/%h want 2/0300", rsp_id, rsp_data); end
      n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL mul_model: got %h want %h", rsp_data, e.data); end
      tick();
      issue(2, 2'b11, 16'h0300, 16'h0200, tg);
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tg < 0 || tr != tg + DIVC + 1) begin n_fail++; $display("FAIL div_latency: got %0d want %0d", tr - tg, DIVC + 1); end
      n_checks++; if ({rsp_id, rsp_data} !== {2'd2, 16'h0180}) begin n_fail++; $display("FAIL div_data: got %0d/%h want 2/0180", rsp_id, rsp_data); end
      n_checks++; if ({rsp_data, rsp_upflow, rsp_downflow} !== {e.data, e.up, e.dn}) begin n_fail++; $display("FAIL div_model: got %h/%b%b want %h/%b%b", rsp_data, rsp_upflow, rsp_downflow, e.data, e.up, e.dn); end
      tick();
   endtask

   task automatic test_boundaries();
      logic [1:0]   ops [5];
      logic [W-1:0] as  [5];
      logic [W-1:0] bs  [5];
      int   tg, tr;
      exp_t e;
      ops = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
      as  = '{16'hFF80, 16'h0100, 16'h7F00, 16'hFD00, 16'h7F00};
      bs  = '{16'h0001, 16'h0000, 16'h0200, 16'h0200, 16'hFF00};
      for (int k = 0; k < 5; k++) begin
         issue(k % NREQ, ops[k], as[k], bs[k], tg);
         await_rsp(tr);
         e = pop_exp();
         n_checks++;
         if (tg < 0 || tr < 0 || {rsp_id, rsp_data, rsp_upflow, rsp_downflow} !== {e.id, e.data, e.up, e.dn}) begin
            n_fail++;
            $display("FAIL bound_%0d: got %0d/%h/%b%b want %0d/%h/%b%b", k, rsp_id, rsp_data, rsp_upflow, rsp_downflow, e.id, e.data, e.up, e.dn);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      int   tg, tr;
      exp_t e;
      ref_a = 16'h8000;
      ref_b = 16'h0100;
      issue(1, 2'b01, 16'h8000, 16'h0100, tg);
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tr < 0 || rsp_data !== 16'h8000 || rsp_upflow !== 1'b1) begin n_fail++; $display("FAIL sat_value: got %h/%b want 8000/1", rsp_data, rsp_upflow); end
      n_checks++; if ({rsp_data, rsp_upflow, rsp_downflow} !== {ref_out, ref_up, ref_dn}) begin n_fail++; $display("FAIL sat_ref_unit: got %h/%b%b want %h/%b%b", rsp_data, rsp_upflow, rsp_downflow, ref_out, ref_up, ref_dn); end
      n_checks++; if ({rsp_data, rsp_upflow, rsp_downflow} !== {e.data, e.up, e.dn}) begin n_fail++; $display("FAIL sat_model: got %h/%b%b want %h/%b%b", rsp_data, rsp_upflow, rsp_downflow, e.data, e.up, e.dn); end
      tick();
   endtask

   task automatic test_arbitration();
      int            ord [5];
      int            g, tg, tr, prev;
      logic [W-1:0]  hd;
      logic [IW-1:0] hid;
      logic          ok;
      exp_t          e;
      ord = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 2'b00, 16'(256 * (i + 1)), 16'(16 * (i + 1)));
      for (int k = 0; k < 5; k++)
         sbq.push_back(model(2'b00, 16'(256 * (ord[k] + 1)), 16'(16 * (ord[k] + 1)), IW'(ord[k])));
      req_valid = '1;
      #1;
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         g = -1;
         tg = -1;
         for (int t = 0; t < 50; t++) begin
            if (req_ready != '0) begin
               tg = cyc;
               for (int b = 0; b < NREQ; b++) if (req_ready[b]) g = b;
               break;
            end
            tick();
         end
         n_checks++; if (g != ord[k] || !$onehot(req_ready)) begin n_fail++; $display("FAIL arb_grant_%0d: got %b want req %0d", k, req_ready, ord[k]); end
         if (k == 1 || k == 2 || k == 4) begin
            n_checks++; if (tg - prev != 3) begin n_fail++; $display("FAIL arb_interval_%0d: got %0d want 3", k, tg - prev); end
         end
         prev = tg;
         tick();
         if (k != 0 && g >= 0) req_valid[g] = 1'b0;
         if (k == 2) rsp_ready = 1'b0;
         await_rsp(tr);
         if (k == 2) begin
            hd = rsp_data;
            hid = rsp_id;
            for (int s = 0; s < 5; s++) begin
               tick();
               ok = (rsp_valid === 1'b1) && (rsp_data === hd) && (rsp_id === hid) && (req_ready === '0);
               n_checks++; if (!ok || tr < 0) begin n_fail++; $display("FAIL arb_hold_%0d: valid %b data %h id %0d ready %b", s, rsp_valid, rsp_data, rsp_id, req_ready); end
            end
            rsp_ready = 1'b1;
         end
         e = pop_exp();
         n_checks++; if (tr < 0 || {rsp_id, rsp_data} !== {e.id, e.data}) begin n_fail++; $display("FAIL arb_rsp_%0d: got %0d/%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data); end
         tick();
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid_div();
      int   tg, tr;
      logic seen;
      exp_t e;
      issue(3, 2'b11, 16'h0300, 16'h0200, tg);
      tick();
      rst = 1'b1;
      #1;
      n_checks++; if (tg < 0 || rsp_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL mid_rst_ctl: valid %b ready %b", rsp_valid, req_ready); end
      n_checks++; if ({rsp_id, rsp_data, rsp_upflow, rsp_downflow} !== '0) begin n_fail++; $display("FAIL mid_rst_rsp: got %0d/%h want 0/0000", rsp_id, rsp_data); end
      if (sbq.size() > 0) void'(sbq.pop_back());
      seen = 1'b0;
      repeat (2) begin tick(); if (rsp_valid !== 1'b0) seen = 1'b1; end
      rst = 1'b0;
      repeat (DIVC + 4) begin tick(); if (rsp_valid !== 1'b0) seen = 1'b1; end
      n_checks++; if (seen) begin n_fail++; $display("FAIL mid_rst_norsp: got valid 1 want 0"); end
      set_req(1, 2'b00, 16'h0080, 16'h0080);
      set_req(2, 2'b01, 16'h0080, 16'h0180);
      req_valid[1] = 1'b1;
      req_valid[2] = 1'b1;
      sbq.push_back(model(2'b00, 16'h0080, 16'h0080, 2'd1));
      sbq.push_back(model(2'b01, 16'h0080, 16'h0180, 2'd2));
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL post_rst_grant: got %b want 0010", req_ready); end
      tick();
      req_valid[1] = 1'b0;
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tr < 0 || {rsp_id, rsp_data, rsp_upflow} !== {e.id, e.data, e.up}) begin n_fail++; $display("FAIL post_rst_add: got %0d/%h want %0d/%h", rsp_id, rsp_data, e.id, e.data); end
      tick();
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL post_rst_grant2: got %b want 0100", req_ready); end
      tick();
      req_valid[2] = 1'b0;
      await_rsp(tr);
      e = pop_exp();
      n_checks++; if (tr < 0 || {rsp_id, rsp_data, rsp_upflow} !== {e.id, e.data, e.up}) begin n_fail++; $display("FAIL post_rst_sub: got %0d/%h want %0d/%h", rsp_id, rsp_data, e.id, e.data); end
      tick();
   endtask

   initial begin
      rsp_ready = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      ref_a     = '0;
      ref_b     = '0;
      test_reset();
      test_add();
      test_mul_div();
      test_boundaries();
      test_saturation();
      test_arbitration();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
